// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the mantissa normalizer.
package fp_norm_pkg;

  // Normalizer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } norm_state_e;

  // Default widths: mantissa incl. guard/round, biased exponent, shift per cycle.
  localparam int DEF_IN_WIDTH  = 27;
  localparam int DEF_EXP_WIDTH = 8;
  localparam int DEF_STEP      = 4;

  // True when the leading-one index flags a zero mantissa. The encoder emits
  // all-ones for zero; any index at or beyond the width is treated the same.
  function automatic logic pos_is_zero(input logic [31:0] pos, input int in_width);
    return pos >= 32'(in_width);
  endfunction

endpackage

// File: rtl/norm_shift_step.sv
// One iteration of the normalizing shift: move left by min(remaining, STEP).
module norm_shift_step #(
  parameter int IN_WIDTH  = 27,
  parameter int POS_WIDTH = 6,
  parameter int STEP      = 4
) (
  input  logic [IN_WIDTH-1:0]  mant_i,
  input  logic [POS_WIDTH-1:0] rem_i,
  output logic [IN_WIDTH-1:0]  mant_o,
  output logic [POS_WIDTH-1:0] rem_o
);

  localparam logic [POS_WIDTH-1:0] STEP_P = POS_WIDTH'(STEP);

  logic [POS_WIDTH-1:0] amt;

  // Clip the step to what is left, shift by it, and account for it.
  always_comb begin
    amt    = (rem_i > STEP_P) ? STEP_P : rem_i;
    mant_o = mant_i << amt;
    rem_o  = rem_i - amt;
  end

endmodule

// File: rtl/mant_normalizer.sv
// Left-normalizer for FPU mantissas with exponent clamping to denormal.
// Build option MANT_NORM_ONE_CYCLE_EN: do the whole shift with one barrel
// shift at accept time instead of STEP bits per cycle.
module mant_normalizer
  import fp_norm_pkg::*;
#(
  parameter  int IN_WIDTH  = DEF_IN_WIDTH,
  parameter  int EXP_WIDTH = DEF_EXP_WIDTH,
  parameter  int STEP      = DEF_STEP,
  localparam int POS_WIDTH = $clog2(IN_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_mant,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [POS_WIDTH-1:0] in_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_WIDTH-1:0]  out_mant,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_underflow
);

  localparam int EXP_X_W = EXP_WIDTH + 1;
  localparam logic [POS_WIDTH-1:0] TOP_POS = POS_WIDTH'(IN_WIDTH - 1);

  norm_state_e          state_q, state_d;
  logic [IN_WIDTH-1:0]  mant_q, mant_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 zero_q, zero_d;
  logic                 uf_q, uf_d;

  // Accept-time decode
  logic                 zero_in;
  logic [POS_WIDTH-1:0] shamt;
  logic [EXP_X_W-1:0]   exp_x, shamt_x;
  logic [POS_WIDTH-1:0] acc_shift;
  logic [EXP_WIDTH-1:0] acc_exp;
  logic                 acc_uf;
  logic [IN_WIDTH-1:0]  acc_mant;

  // Decide shift distance, final exponent and underflow for the incoming operand.
  // Widening to EXP_WIDTH+1 keeps the exponent-vs-shift comparison from wrapping.
  always_comb begin
    zero_in   = pos_is_zero(32'(in_pos), IN_WIDTH);
    shamt     = TOP_POS - in_pos;
    exp_x     = {1'b0, in_exp};
    shamt_x   = EXP_X_W'(shamt);
    acc_shift = '0;
    acc_exp   = '0;
    acc_uf    = 1'b0;
    acc_mant  = in_mant;
    if (zero_in) begin
      acc_mant = '0;
    end else if ((exp_x > shamt_x) || (shamt == '0)) begin
      acc_shift = shamt;
      acc_exp   = EXP_WIDTH'(exp_x - shamt_x);
    end else begin
      // Exponent runs out first: stop at exponent 1's worth of shift, report denormal.
      acc_shift = (in_exp == '0) ? '0 : POS_WIDTH'(in_exp - EXP_WIDTH'(1));
      acc_uf    = 1'b1;
    end
  end

`ifdef MANT_NORM_ONE_CYCLE_EN

  // Next state and datapath: single barrel shift at accept, straight to DONE.
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mant_d  = acc_mant << acc_shift;
          exp_d   = acc_exp;
          zero_d  = zero_in;
          uf_d    = acc_uf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

`else

  localparam logic [POS_WIDTH-1:0] STEP_P = POS_WIDTH'(STEP);

  logic [POS_WIDTH-1:0] rem_q, rem_d;
  logic [IN_WIDTH-1:0]  step_mant;
  logic [POS_WIDTH-1:0] step_rem;

  norm_shift_step #(
    .IN_WIDTH  (IN_WIDTH),
    .POS_WIDTH (POS_WIDTH),
    .STEP      (STEP)
  ) u_step (
    .mant_i (mant_q),
    .rem_i  (rem_q),
    .mant_o (step_mant),
    .rem_o  (step_rem)
  );

  // Next state and datapath: load at accept, then shift STEP bits per cycle.
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mant_d  = acc_mant;
          exp_d   = acc_exp;
          zero_d  = zero_in;
          uf_d    = acc_uf;
          rem_d   = acc_shift;
          state_d = (acc_shift == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        mant_d = step_mant;
        rem_d  = step_rem;
        if (rem_q <= STEP_P) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and remaining-shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
      rem_q   <= rem_d;
    end
  end

`endif

  // Handshake and result outputs; registers hold steady while in DONE.
  always_comb begin
    in_ready      = (state_q == ST_IDLE) && !rst;
    out_valid     = (state_q == ST_DONE);
    out_mant      = mant_q;
    out_exp       = exp_q;
    out_zero      = zero_q;
    out_underflow = uf_q;
  end

endmodule

// File: tb/tb_mant_normalizer.sv
// Directed bench for mant_normalizer with hand-computed results.
module tb_mant_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic [5:0]  in_pos = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [26:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_underflow;

  int total = 0;
  int bad   = 0;

  mant_normalizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mant       (in_mant),
    .in_exp        (in_exp),
    .in_pos        (in_pos),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mant      (out_mant),
    .out_exp       (out_exp),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_lat(input int shift);
`ifdef MANT_NORM_ONE_CYCLE_EN
    return 1;
`else
    return 1 + (shift + 3) / 4;
`endif
  endfunction

  // Present one operand, accept it, then wait (bounded) for the result.
  task automatic launch(input logic [26:0] m, input logic [7:0] e, input logic [5:0] p,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mant = m; in_exp = e; in_pos = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mant = 27'h5A5A5A5; in_exp = 8'hC3; in_pos = 6'd3;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [26:0] m, input logic [7:0] e,
                        input logic [5:0] p, input logic [26:0] xm, input logic [7:0] xe,
                        input logic xz, input logic xu, input int shift, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ":in_ready_pre"}, in_ready, 1);
    launch(m, e, p, lat);
    check({tag, ":latency"}, lat, exp_lat(shift));
    check({tag, ":mant"}, out_mant, xm);
    check({tag, ":exp"}, out_exp, xe);
    check({tag, ":zero"}, out_zero, xz);
    check({tag, ":uf"}, out_underflow, xu);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, out_valid, 1);
      check({tag, ":hold_mant"}, out_mant, xm);
      check({tag, ":hold_exp"}, out_exp, xe);
      check({tag, ":hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":in_ready_post"}, in_ready, 1);
    check({tag, ":valid_post"}, out_valid, 0);
    $display("op %s: mant=0x%07h exp=%0d zero=%0b uf=%0b lat=%0d", tag, out_mant, out_exp,
             out_zero, out_underflow, lat);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    check("rst:in_ready", in_ready, 0);
    check("rst:valid", out_valid, 0);
    check("rst:mant", out_mant, 0);
    check("rst:exp", out_exp, 0);
    check("rst:zero", out_zero, 0);
    check("rst:uf", out_underflow, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst:in_ready_after", in_ready, 1);

    //     tag        in_mant       exp   pos   out_mant      out_exp zero uf shift hold
    run_op("t1_norm", 27'h4000000, 8'd100, 6'd26, 27'h4000000, 8'd100, 0, 0, 0, 0);
    run_op("t2_full", 27'h0000001, 8'd100, 6'd0, 27'h4000000, 8'd74, 0, 0, 26, 0);
    run_op("t3_zero", 27'h0000000, 8'd55, 6'h3F, 27'h0000000, 8'd0, 1, 0, 0, 0);
    run_op("t4_clamp", 27'h0000100, 8'd10, 6'd8, 27'h0020000, 8'd0, 0, 1, 9, 0);
    run_op("t5_hold", 27'h0000001, 8'd100, 6'd0, 27'h4000000, 8'd74, 0, 0, 26, 5);
    run_op("eq_exp", 27'h0000100, 8'd18, 6'd8, 27'h2000000, 8'd0, 0, 1, 17, 0);
    run_op("exp_p1", 27'h0000100, 8'd19, 6'd8, 27'h4000000, 8'd1, 0, 0, 18, 0);
    run_op("exp0", 27'h0000100, 8'd0, 6'd8, 27'h0000100, 8'd0, 0, 1, 0, 0);
    run_op("exp0_top", 27'h4000000, 8'd0, 6'd26, 27'h4000000, 8'd0, 0, 0, 0, 0);
    run_op("step4", 27'h0400000, 8'd100, 6'd22, 27'h4000000, 8'd96, 0, 0, 4, 0);
    run_op("step5", 27'h0200000, 8'd100, 6'd21, 27'h4000000, 8'd95, 0, 0, 5, 0);
    run_op("zero27", 27'h0000000, 8'd7, 6'd27, 27'h0000000, 8'd0, 1, 0, 0, 0);
    run_op("mixed", 27'h00012AB, 8'd200, 6'd12, 27'h4AAC000, 8'd186, 0, 0, 14, 1);

    // Reset mid-shift drops the operand.
    @(negedge clk);
    in_valid = 1'b1; in_mant = 27'h0000001; in_exp = 8'd100; in_pos = 6'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6:rst_in_ready", in_ready, 0);
    check("t6:rst_valid", out_valid, 0);
    check("t6:rst_mant", out_mant, 0);
    check("t6:rst_exp", out_exp, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t6:in_ready_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("t6:no_output", seen, 0);
    $display("op t6_rst: dropped operand, valid_seen=%0d", seen);
    run_op("t6_next", 27'h4000000, 8'd100, 6'd26, 27'h4000000, 8'd100, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
